// File: rtl/device_dispatcher.sv
// rtl/device_dispatcher.sv - sequences instruction words onto the shared device bus
//
// Each accepted word {data, addr, op, dev} is copied to main_bus. The dispatcher
// waits for the target device to be idle, strobes its chip-select for one cycle,
// and then waits for it to report done. Bad device indices and stalled devices
// raise sticky error flags and park the FSM in HALT until clr_err is pulsed.
module device_dispatcher #(
  parameter int          N_DEV   = 8,
  parameter int unsigned TIMEOUT = 16'hFFFF,
  parameter int          CW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_word,
  input  logic              clr_err,
  output logic [31:0]       main_bus,
  output logic [N_DEV-1:0]  dev_cs,
  input  logic [N_DEV-1:0]  dev_rdy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_baddev,
  output logic [CW-1:0]     cmd_count,
  output logic [3:0]        state
);

  // Index width needed to address one of the N_DEV select lines.
  localparam int IW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  // Last timer value before a wait is declared stuck.
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DECODE  = 4'd1,
    WAITRDY = 4'd2,
    ISSUE   = 4'd3,
    GUARD   = 4'd4,
    BUSY    = 4'd5,
    DONE    = 4'd6,
    ERR     = 4'd7,
    HALT    = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     bus_q, bus_d;
  logic [3:0]      dev_q, dev_d;
  logic [CW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   count_q, count_d;
  logic            tmo_q, tmo_d;
  logic            bad_q, bad_d;

  logic [IW-1:0]   dev_idx;
  logic            dev_in_range;
  logic            rdy_sel;
  logic            timer_expired;

  // Selected device decode: only meaningful once the index has passed DECODE.
  assign dev_idx       = dev_q[IW-1:0];
  assign dev_in_range  = ({28'd0, dev_q} < $unsigned(N_DEV));
  assign rdy_sel       = dev_in_range & dev_rdy[dev_idx];
  assign timer_expired = (timer_q == TMAX);

  // State and datapath registers; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bus_q   <= '0;
      dev_q   <= '0;
      timer_q <= '0;
      count_q <= '0;
      tmo_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      dev_q   <= dev_d;
      timer_q <= timer_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state logic: one instruction walks IDLE..DONE, or detours via ERR to HALT.
  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    dev_d   = dev_q;
    timer_d = timer_q;
    count_d = count_q;
    tmo_d   = tmo_q;
    bad_d   = bad_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          bus_d   = cmd_word;
          dev_d   = cmd_word[3:0];
          state_d = DECODE;
        end
      end

      DECODE: begin
        if (dev_q == 4'd0) begin
          // Device 0 is a NOP: complete without touching the bus.
          state_d = DONE;
        end else if (!dev_in_range) begin
          bad_d   = 1'b1;
          state_d = ERR;
        end else begin
          timer_d = '0;
          state_d = WAITRDY;
        end
      end

      WAITRDY: begin
        if (rdy_sel) begin
          state_d = ISSUE;
        end else if (timer_expired) begin
          tmo_d   = 1'b1;
          state_d = ERR;
        end else begin
          timer_d = timer_q + CW'(1);
        end
      end

      ISSUE: begin
        state_d = GUARD;
      end

      GUARD: begin
        // The device may still show idle for a cycle after cs; skip that sample.
        timer_d = '0;
        state_d = BUSY;
      end

      BUSY: begin
        if (rdy_sel) begin
          state_d = DONE;
        end else if (timer_expired) begin
          tmo_d   = 1'b1;
          state_d = ERR;
        end else begin
          timer_d = timer_q + CW'(1);
        end
      end

      DONE: begin
        count_d = count_q + CW'(1);
        state_d = IDLE;
      end

      ERR: begin
        state_d = HALT;
      end

      HALT: begin
        if (clr_err) begin
          tmo_d   = 1'b0;
          bad_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: strobes are pure functions of the registered state.
  always_comb begin
    cmd_ready   = (state_q == IDLE);
    done        = (state_q == DONE);
    dev_cs      = '0;
    if (state_q == ISSUE && dev_in_range) begin
      dev_cs = N_DEV'(1) << dev_idx;
    end
    main_bus    = bus_q;
    err_timeout = tmo_q;
    err_baddev  = bad_q;
    cmd_count   = count_q;
    state       = state_q;
  end

endmodule

// File: tb/tb_device_dispatcher.sv
// tb/tb_device_dispatcher.sv - self-checking bench for device_dispatcher
module tb_device_dispatcher;

  localparam int N_DEV   = 8;
  localparam int TIMEOUT = 16;
  localparam int CW      = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [31:0]       cmd_word;
  logic              clr_err;
  logic [31:0]       main_bus;
  logic [N_DEV-1:0]  dev_cs;
  logic [N_DEV-1:0]  dev_rdy;
  logic              done;
  logic              err_timeout;
  logic              err_baddev;
  logic [CW-1:0]     cmd_count;
  logic [3:0]        state;

  logic [N_DEV-1:0]  model_rdy;
  logic [N_DEV-1:0]  force_low;
  int                busy_len [N_DEV];
  int                hold     [N_DEV];
  bit                pend     [N_DEV];

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;

  assign dev_rdy = model_rdy & ~force_low;

  device_dispatcher #(.N_DEV(N_DEV), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_word(cmd_word), .clr_err(clr_err), .main_bus(main_bus),
    .dev_cs(dev_cs), .dev_rdy(dev_rdy), .done(done),
    .err_timeout(err_timeout), .err_baddev(err_baddev),
    .cmd_count(cmd_count), .state(state)
  );

  always #5 clk = ~clk;

  // Device model: rdy drops one cycle after cs, returns busy_len cycles later.
  always @(negedge clk) begin
    for (int i = 0; i < N_DEV; i++) begin
      if (dev_cs[i]) begin
        pend[i] = 1'b1;
      end else if (pend[i]) begin
        pend[i] = 1'b0;
        if (busy_len[i] > 0) begin
          model_rdy[i] = 1'b0;
          hold[i] = busy_len[i];
        end
      end else if (hold[i] > 0) begin
        hold[i] = hold[i] - 1;
        if (hold[i] == 0) model_rdy[i] = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Issue one word from IDLE and record what the DUT does, relative to the accept edge (k=0).
  task automatic run_cmd(input logic [31:0] w, output int cs_n, output logic [7:0] cs_v,
                         output int cs_k, output int dn_n, output int dn_k,
                         output int end_k, output logic [3:0] end_s, output bit bus_ok);
    cs_n = 0; cs_v = '0; cs_k = -1; dn_n = 0; dn_k = -1; end_k = -1; end_s = 4'hF; bus_ok = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_word  = w;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (dev_cs != '0) begin cs_n++; cs_v = dev_cs; cs_k = k; end
      if (done) begin dn_n++; dn_k = k; end
      if (state inside {[4'd1:4'd7]} && main_bus !== w) bus_ok = 1'b0;
      if (k > 0 && (state == 4'd0 || state == 4'd8)) begin
        end_k = k;
        end_s = state;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [7:0]  low_mask;
    int          blen;
    logic [7:0]  cs_val;
    int          cs_at;
    int          done_at;
    int          end_at;
    logic [3:0]  end_state;
    logic        tmo;
    logic        bad;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int cs_n, cs_k, dn_n, dn_k, end_k, acc, saw, dn_cnt, last_dn, cyc;
    logic [7:0] cs_v;
    logic [3:0] end_s;
    bit bus_ok;
    int dv;

    vecs[0] = '{32'h1234_5602, 8'h00, 10,  8'h04,  2, 14, 15, 4'd0, 1'b0, 1'b0};
    vecs[1] = '{32'hA5A5_C313, 8'h00, 0,   8'h08,  2,  5,  6, 4'd0, 1'b0, 1'b0};
    vecs[2] = '{32'h0001_FF07, 8'h00, 3,   8'h80,  2,  7,  8, 4'd0, 1'b0, 1'b0};
    vecs[3] = '{32'hDEAD_BE00, 8'h00, 0,   8'h00, -1,  1,  2, 4'd0, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0009, 8'h00, 0,   8'h00, -1, -1,  2, 4'd8, 1'b0, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 8'h00, 0,   8'h00, -1, -1,  2, 4'd8, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_0018, 8'h00, 0,   8'h00, -1, -1,  2, 4'd8, 1'b0, 1'b1};
    vecs[7] = '{32'h0000_0011, 8'h02, 0,   8'h00, -1, -1, 18, 4'd8, 1'b1, 1'b0};
    vecs[8] = '{32'h0000_0045, 8'h00, 100, 8'h20,  2, -1, 21, 4'd8, 1'b1, 1'b0};
    vecs[9] = '{32'h7777_1022, 8'hFB, 1,   8'h04,  2,  5,  6, 4'd0, 1'b0, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; clr_err = 1'b0; cmd_word = '0;
    force_low = '0; model_rdy = '1;
    for (int i = 0; i < N_DEV; i++) begin busy_len[i] = 0; hold[i] = 0; pend[i] = 1'b0; end

    @(negedge clk);
    @(negedge clk);
    chk("rst_state", state, 4'd0);
    chk("rst_cs", dev_cs, 8'h00);
    chk("rst_bus", main_bus, 32'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", {err_timeout, err_baddev}, 2'b00);
    chk("rst_count", cmd_count, 4'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1'b1);

    // Table-driven single-command scenarios.
    for (int v = 0; v < 10; v++) begin
      force_low = vecs[v].low_mask;
      dv = int'(vecs[v].word[3:0]);
      if (dv < N_DEV) busy_len[dv] = vecs[v].blen;
      run_cmd(vecs[v].word, cs_n, cs_v, cs_k, dn_n, dn_k, end_k, end_s, bus_ok);
      if (vecs[v].done_at >= 0) exp_count = (exp_count + 1) % 16;
      chk($sformatf("v%0d_cs_pulses", v), cs_n, (vecs[v].cs_at >= 0) ? 1 : 0);
      if (vecs[v].cs_at >= 0) begin
        chk($sformatf("v%0d_cs_val", v), cs_v, vecs[v].cs_val);
        chk($sformatf("v%0d_cs_at", v), cs_k, vecs[v].cs_at);
      end
      chk($sformatf("v%0d_done_pulses", v), dn_n, (vecs[v].done_at >= 0) ? 1 : 0);
      if (vecs[v].done_at >= 0) chk($sformatf("v%0d_done_at", v), dn_k, vecs[v].done_at);
      chk($sformatf("v%0d_end_at", v), end_k, vecs[v].end_at);
      chk($sformatf("v%0d_end_state", v), end_s, vecs[v].end_state);
      chk($sformatf("v%0d_err_timeout", v), err_timeout, vecs[v].tmo);
      chk($sformatf("v%0d_err_baddev", v), err_baddev, vecs[v].bad);
      chk($sformatf("v%0d_bus_stable", v), bus_ok, 1'b1);
      chk($sformatf("v%0d_count", v), cmd_count, exp_count[3:0]);
      if (vecs[v].end_state == 4'd8) begin
        chk($sformatf("v%0d_halt_ready", v), cmd_ready, 1'b0);
        @(negedge clk);
        chk($sformatf("v%0d_halt_hold", v), state, 4'd8);
        clr_err = 1'b1; cmd_valid = 1'b1; cmd_word = 32'hCAFE_0003;
        @(negedge clk);
        clr_err = 1'b0; cmd_valid = 1'b0;
        chk($sformatf("v%0d_clr_state", v), state, 4'd0);
        chk($sformatf("v%0d_clr_ready", v), cmd_ready, 1'b1);
        chk($sformatf("v%0d_clr_flags", v), {err_timeout, err_baddev}, 2'b00);
        chk($sformatf("v%0d_clr_no_accept", v), main_bus, vecs[v].word);
      end
      force_low = '0;
    end

    // clr_err while idle must not disturb anything.
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("idle_clr_state", state, 4'd0);
    chk("idle_clr_count", cmd_count, exp_count[3:0]);

    // Three NOPs back-to-back with cmd_valid held.
    acc = 0; dn_cnt = 0; last_dn = -1; saw = 0;
    cmd_word = 32'h0000_0100;
    cmd_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (acc == 3) cmd_valid = 1'b0;
      if (dev_cs != '0) saw++;
      if (done) begin
        if (last_dn >= 0) chk($sformatf("nop_spacing%0d", dn_cnt), c - last_dn, 3);
        last_dn = c;
        dn_cnt++;
        exp_count = (exp_count + 1) % 16;
      end
      if (state == 4'd0 && cmd_valid) acc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("nop_done_pulses", dn_cnt, 3);
    chk("nop_no_cs", saw, 0);
    chk("nop_count", cmd_count, exp_count[3:0]);

    // Reset asserted while the device is busy.
    busy_len[2] = 10;
    cmd_word = 32'h1234_5602;
    cmd_valid = 1'b1;
    saw = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (state == 4'd5) begin saw = 1; break; end
    end
    chk("rst_busy_reached", saw, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    chk("midrst_state", state, 4'd0);
    chk("midrst_cs", dev_cs, 8'h00);
    chk("midrst_bus", main_bus, 32'h0);
    chk("midrst_count", cmd_count, 4'h0);
    chk("midrst_flags", {err_timeout, err_baddev}, 2'b00);
    dn_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dn_cnt++;
      @(negedge clk);
    end
    chk("midrst_no_done", dn_cnt, 0);

    // Counter wrap: 15 completions, then one more.
    for (int n = 0; n < 15; n++) begin
      run_cmd(32'h0000_0000, cs_n, cs_v, cs_k, dn_n, dn_k, end_k, end_s, bus_ok);
      if (dn_n == 1) exp_count = (exp_count + 1) % 16;
    end
    chk("wrap_pre_count", cmd_count, 4'hF);
    busy_len[3] = 0;
    run_cmd(32'h0000_0013, cs_n, cs_v, cs_k, dn_n, dn_k, end_k, end_s, bus_ok);
    chk("wrap_done_pulses", dn_n, 1);
    chk("wrap_done_at", dn_k, 5);
    chk("wrap_count", cmd_count, 4'h0);

    cyc = checks;
    $display("TB_RESULT checks=%0d failures=%0d", cyc, failures);
    $finish;
  end

endmodule
